// File: rtl/rbcp_pkg.sv
// Shared definitions for the RBCP register responder: bus widths,
// FSM state encoding and the captured-operation encoding.
package rbcp_pkg;

  localparam int RBCP_ADDR_W = 32;
  localparam int RBCP_DATA_W = 8;

  // Captured operation: a combined WE+RE strobe is recorded as a write.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } rbcp_state_e;

endpackage

// File: rtl/rbcp_addr_decode.sv
// Combinational window compare for the RBCP responder.
// The window is 2*REG_NUM bytes starting at BASE_ADDR (aligned to its size):
// lower half is the RW bank, upper half the read-only status window.
// Optional feature macro: RBCP_SLAVE_STS_EN (status half decoded only when defined).
module rbcp_addr_decode
  import rbcp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          REG_NUM   = 16,
  localparam int         IDX_W     = $clog2(REG_NUM)
) (
  input  logic [RBCP_ADDR_W-1:0] addr_i,
  output logic                   rw_hit_o,
  output logic                   sts_hit_o,
  output logic [IDX_W-1:0]       index_o
);

  logic win_match_s;

  // Full compare of all address bits above the window, then split on the half-select bit.
  always_comb begin
    win_match_s = (((addr_i ^ BASE_ADDR) >> (IDX_W + 1)) == 32'h0000_0000);
    index_o     = addr_i[IDX_W-1:0];
    rw_hit_o    = win_match_s & ~addr_i[IDX_W];
`ifdef RBCP_SLAVE_STS_EN
    sts_hit_o   = win_match_s & addr_i[IDX_W];
`else
    sts_hit_o   = 1'b0;
`endif
  end

endmodule

// File: rtl/rbcp_reg_slave.sv
// Byte-wide SiTCP RBCP register responder (USRCLK domain).
// Fixed two-cycle strobe-to-ACK latency; misses and aborted accesses are
// left unacknowledged so the SiTCP core times them out.
// Optional feature macro: RBCP_SLAVE_STS_EN (read-only status window over STS_IN).
module rbcp_reg_slave
  import rbcp_pkg::*;
#(
  parameter logic [31:0]            BASE_ADDR = 32'h0000_0000,
  parameter int                     REG_NUM   = 16,
  parameter logic [8*REG_NUM-1:0]   REG_INIT  = {REG_NUM{8'h00}}
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      RBCP_ACT,
  input  logic [RBCP_ADDR_W-1:0]    RBCP_ADDR,
  input  logic                      RBCP_WE,
  input  logic [RBCP_DATA_W-1:0]    RBCP_WD,
  input  logic                      RBCP_RE,
  output logic                      RBCP_ACK,
  output logic [RBCP_DATA_W-1:0]    RBCP_RD,
  output logic [8*REG_NUM-1:0]      REG_Q,
  output logic [REG_NUM-1:0]        WR_STB,
  input  logic [8*REG_NUM-1:0]      STS_IN,
  output logic                      PROTO_ERR
);

  localparam int IDX_W = $clog2(REG_NUM);

  rbcp_state_e                state_q, state_d;
  logic [RBCP_ADDR_W-1:0]     addr_q, addr_d;
  logic [RBCP_DATA_W-1:0]     wd_q, wd_d;
  logic                       op_q, op_d;
  logic [8*REG_NUM-1:0]       reg_q, reg_d;
  logic [REG_NUM-1:0]         wr_stb_q, wr_stb_d;
  logic [RBCP_DATA_W-1:0]     rd_q, rd_d;
  logic [RBCP_DATA_W-1:0]     rd_out_q, rd_out_d;
  logic                       ack_q, ack_d;
  logic                       perr_q, perr_d;

  logic                       rw_hit_s;
  logic                       sts_hit_s;
  logic [IDX_W-1:0]           index_s;
  logic [RBCP_DATA_W-1:0]     sts_byte_s;
  logic                       strobe_s;

  rbcp_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .REG_NUM   (REG_NUM)
  ) u_decode (
    .addr_i    (addr_q),
    .rw_hit_o  (rw_hit_s),
    .sts_hit_o (sts_hit_s),
    .index_o   (index_s)
  );

`ifdef RBCP_SLAVE_STS_EN
  assign sts_byte_s = STS_IN[{index_s, 3'b000} +: 8];
`else
  // Status inputs are intentionally ignored when the status window is not built.
  logic unused_sts_s;
  assign unused_sts_s = ^STS_IN;
  assign sts_byte_s   = 8'h00;
`endif

  assign strobe_s = RBCP_WE | RBCP_RE;

  // Next-state, register-bank update and response generation.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    op_d     = op_q;
    reg_d    = reg_q;
    wr_stb_d = '0;
    rd_d     = rd_q;
    rd_out_d = 8'h00;
    ack_d    = 1'b0;
    perr_d   = perr_q;
    case (state_q)
      IDLE: begin
        if (RBCP_ACT && strobe_s) begin
          addr_d  = RBCP_ADDR;
          wd_d    = RBCP_WD;
          op_d    = RBCP_WE ? OP_WRITE : OP_READ;
          state_d = DECODE;
          if (RBCP_WE && RBCP_RE) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (strobe_s) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_q;
        end
        if (!RBCP_ACT) begin
          state_d = IDLE;
        end else if (rw_hit_s || sts_hit_s) begin
          state_d = RESP;
          if (op_q == OP_WRITE) begin
            rd_d = 8'h00;
            if (rw_hit_s) begin
              reg_d[{index_s, 3'b000} +: 8] = wd_q;
              wr_stb_d[index_s]             = 1'b1;
            end else begin
              reg_d = reg_q;
            end
          end else begin
            if (rw_hit_s) begin
              rd_d = reg_q[{index_s, 3'b000} +: 8];
            end else begin
              rd_d = sts_byte_s;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (strobe_s) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_q;
        end
        ack_d    = 1'b1;
        rd_out_d = rd_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0000_0000;
      wd_q     <= 8'h00;
      op_q     <= OP_READ;
      reg_q    <= REG_INIT;
      wr_stb_q <= '0;
      rd_q     <= 8'h00;
      rd_out_q <= 8'h00;
      ack_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      op_q     <= op_d;
      reg_q    <= reg_d;
      wr_stb_q <= wr_stb_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      ack_q    <= ack_d;
      perr_q   <= perr_d;
    end
  end

  assign RBCP_ACK  = ack_q;
  assign RBCP_RD   = rd_out_q;
  assign REG_Q     = reg_q;
  assign WR_STB    = wr_stb_q;
  assign PROTO_ERR = perr_q;

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Directed self-checking bench for rbcp_reg_slave (REG_NUM=16, BASE_ADDR=0x100).
module tb_rbcp_reg_slave;

  localparam logic [31:0]  BASE = 32'h0000_0100;
  localparam int           RN   = 16;
  localparam logic [127:0] INIT = 128'h0000_0000_0000_0000_0000_0000_0000_5A00;

  logic         clk;
  logic         rst_n;
  logic         act;
  logic [31:0]  addr;
  logic         we;
  logic [7:0]   wd;
  logic         re;
  logic         ack;
  logic [7:0]   rd;
  logic [127:0] reg_q;
  logic [15:0]  wr_stb;
  logic [127:0] sts_in;
  logic         perr;

  int           checks;
  int           failures;
  logic [127:0] exp_reg;
  logic         sts_ack;

  rbcp_reg_slave #(
    .BASE_ADDR (BASE),
    .REG_NUM   (RN),
    .REG_INIT  (INIT)
  ) dut (
    .CLK       (clk),
    .RSTn      (rst_n),
    .RBCP_ACT  (act),
    .RBCP_ADDR (addr),
    .RBCP_WE   (we),
    .RBCP_WD   (wd),
    .RBCP_RE   (re),
    .RBCP_ACK  (ack),
    .RBCP_RD   (rd),
    .REG_Q     (reg_q),
    .WR_STB    (wr_stb),
    .STS_IN    (sts_in),
    .PROTO_ERR (perr)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access: strobe at edge n, checks at n+1, n+2, n+3.
  task automatic access(input string tag, input logic w, input logic r,
                        input logic [31:0] a, input logic [7:0] d,
                        input logic exp_ack, input logic [7:0] exp_rd,
                        input logic [15:0] exp_stb);
    @(posedge clk); #1;
    act = 1'b1; we = w; re = r; addr = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_stb"}, {112'h0, wr_stb}, {112'h0, exp_stb});
    chk({tag, "_ack_early"}, {127'h0, ack}, 128'h0);
    @(posedge clk); #1;
    chk({tag, "_ack"}, {127'h0, ack}, {127'h0, exp_ack});
    chk({tag, "_rd"}, {120'h0, rd}, {120'h0, (exp_ack ? exp_rd : 8'h00)});
    chk({tag, "_stb_clr"}, {112'h0, wr_stb}, 128'h0);
    @(posedge clk); #1;
    chk({tag, "_ack_one"}, {127'h0, ack}, 128'h0);
    act = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; act = 1'b0; addr = 32'h0; we = 1'b0; re = 1'b0; wd = 8'h00;
    sts_in = 128'h0;
    exp_reg = INIT;
`ifdef RBCP_SLAVE_STS_EN
    sts_ack = 1'b1;
`else
    sts_ack = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {127'h0, ack}, 128'h0);
    chk("rst_rd", {120'h0, rd}, 128'h0);
    chk("rst_regq", reg_q, INIT);
    chk("rst_stb", {112'h0, wr_stb}, 128'h0);
    chk("rst_perr", {127'h0, perr}, 128'h0);
    rst_n = 1'b1;

    // Write A5 to register 3.
    access("wr3", 1'b1, 1'b0, BASE + 32'd3, 8'hA5, 1'b1, 8'h00, 16'h0008);
    exp_reg[31:24] = 8'hA5;
    chk("wr3_regq", reg_q, exp_reg);

    // Read it back.
    access("rd3", 1'b0, 1'b1, BASE + 32'd3, 8'h00, 1'b1, 8'hA5, 16'h0000);
    access("rd1_init", 1'b0, 1'b1, BASE + 32'd1, 8'h00, 1'b1, 8'h5A, 16'h0000);

    // Status window read and write.
    sts_in[23:16] = 8'h3C;
    sts_in[7:0]   = 8'h77;
    access("sts_rd2", 1'b0, 1'b1, BASE + 32'd18, 8'h00, sts_ack, 8'h3C, 16'h0000);
    access("sts_rd0", 1'b0, 1'b1, BASE + 32'd16, 8'h00, sts_ack, 8'h77, 16'h0000);
    access("sts_wr", 1'b1, 1'b0, BASE + 32'd17, 8'h55, sts_ack, 8'h00, 16'h0000);
    chk("sts_wr_regq", reg_q, exp_reg);

    // Out-of-window accesses.
    access("miss_hi", 1'b1, 1'b0, BASE + 32'd32, 8'hFF, 1'b0, 8'h00, 16'h0000);
    access("miss_lo", 1'b1, 1'b0, BASE - 32'd1, 8'hFF, 1'b0, 8'h00, 16'h0000);
    access("miss_far", 1'b0, 1'b1, BASE + 32'h0001_0003, 8'h00, 1'b0, 8'h00, 16'h0000);
    chk("miss_regq", reg_q, exp_reg);
    chk("miss_perr", {127'h0, perr}, 128'h0);

    // RBCP_ACT dropped while in DECODE.
    @(posedge clk); #1;
    act = 1'b1; we = 1'b1; addr = BASE + 32'd1; wd = 8'hEE;
    @(posedge clk); #1;
    we = 1'b0; act = 1'b0;
    @(posedge clk); #1;
    chk("abort_stb", {112'h0, wr_stb}, 128'h0);
    chk("abort_ack1", {127'h0, ack}, 128'h0);
    @(posedge clk); #1;
    chk("abort_ack2", {127'h0, ack}, 128'h0);
    chk("abort_regq", reg_q, exp_reg);
    chk("abort_perr", {127'h0, perr}, 128'h0);

    // WE and RE together: handled as a write, sticky protocol error.
    access("wer", 1'b1, 1'b1, BASE, 8'h11, 1'b1, 8'h00, 16'h0001);
    exp_reg[7:0] = 8'h11;
    chk("wer_regq", reg_q, exp_reg);
    chk("wer_perr", {127'h0, perr}, 128'h1);
    access("wer_rd0", 1'b0, 1'b1, BASE, 8'h00, 1'b1, 8'h11, 16'h0000);
    chk("wer_perr_sticky", {127'h0, perr}, 128'h1);

    // Four-byte burst.
    for (int i = 0; i < 4; i++) begin
      access("burst", 1'b1, 1'b0, BASE + i, 8'(i + 1), 1'b1, 8'h00, 16'(1 << i));
    end
    exp_reg[31:0] = 32'h0403_0201;
    chk("burst_regq", reg_q, exp_reg);

    // Reset pulse in the middle of a further write.
    @(posedge clk); #1;
    act = 1'b1; we = 1'b1; addr = BASE; wd = 8'h99;
    @(posedge clk); #1;
    we = 1'b0;
    @(posedge clk); #1;
    chk("mid_wr_taken", {120'h0, reg_q[7:0]}, 128'h99);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {127'h0, ack}, 128'h0);
    chk("mid_rst_rd", {120'h0, rd}, 128'h0);
    chk("mid_rst_regq", reg_q, INIT);
    chk("mid_rst_stb", {112'h0, wr_stb}, 128'h0);
    chk("mid_rst_perr", {127'h0, perr}, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_ack", {127'h0, ack}, 128'h0);
    end
    chk("post_rst_regq", reg_q, INIT);
    access("post_rst_rd1", 1'b0, 1'b1, BASE + 32'd1, 8'h00, 1'b1, 8'h5A, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
